// File: rtl/dbg_seq_pkg.sv
// Shared types and constants for the debug RAM sequencer: top-level states,
// dump sub-phases and the BRAM word/write-enable constants.
package dbg_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LD_DATA = 3'd1,
      ST_LD_INST = 3'd2,
      ST_RUN     = 3'd3,
      ST_DP_DATA = 3'd4,
      ST_DP_INST = 3'd5,
      ST_DONE    = 3'd6
   } seq_state_t;

   typedef enum logic [1:0] {
      PH_ISSUE   = 2'd0,
      PH_WAIT    = 2'd1,
      PH_PRESENT = 2'd2
   } dump_phase_t;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] WE_ALL     = 4'b1111;

endpackage

// File: rtl/dbg_dump_reader.sv
// Per-word read handshake for the dump phases: issue an address, wait out the
// 1-cycle BRAM latency, then hold the captured word until the consumer takes it.
module dbg_dump_reader
   import dbg_seq_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_active,
   input  logic [31:0] i_addr,
   input  logic        i_sel,
   input  logic [31:0] i_rd_data,
   input  logic        i_out_ready,
   output logic        o_issue,
   output logic        o_handshake,
   output logic        o_out_valid,
   output logic [31:0] o_out_data,
   output logic [31:0] o_out_addr,
   output logic        o_out_sel
);

   dump_phase_t r_phase;
   dump_phase_t w_phase_next;
   logic [31:0] r_data;
   logic [31:0] r_addr;
   logic        r_sel;

   always_comb begin
      w_phase_next = r_phase;
      o_issue      = 1'b0;
      o_handshake  = 1'b0;
      case (r_phase)
         PH_ISSUE: begin
            if (i_active) begin
               o_issue      = 1'b1;
               w_phase_next = PH_WAIT;
            end
         end
         PH_WAIT: w_phase_next = PH_PRESENT;
         PH_PRESENT: begin
            if (i_out_ready) begin
               o_handshake  = 1'b1;
               w_phase_next = PH_ISSUE;
            end
         end
         default: w_phase_next = PH_ISSUE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase <= PH_ISSUE;
         r_data  <= '0;
         r_addr  <= '0;
         r_sel   <= 1'b0;
      end else begin
         r_phase <= w_phase_next;
         // RD2 reflects the address issued one cycle earlier
         if (r_phase == PH_WAIT) begin
            r_data <= i_rd_data;
            r_addr <= i_addr;
            r_sel  <= i_sel;
         end
      end
   end

   assign o_out_valid = (r_phase == PH_PRESENT);
   assign o_out_data  = r_data;
   assign o_out_addr  = r_addr;
   assign o_out_sel   = r_sel;

endmodule

// File: rtl/dbg_ram_sequencer.sv
// Owns the RV32Core debug BRAM ports and core reset: loads Data then Inst RAM
// from a host word stream, runs the core for RUN_CYCLES, then dumps both RAMs.
module dbg_ram_sequencer
   import dbg_seq_pkg::*;
#(
   parameter int BRAM_WORDS = 4096,
   parameter int RUN_CYCLES = 200000,
   parameter int CNT_W      = 32
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [31:0] out_addr,
   output logic        out_sel,
   output logic        Core_RST,
   output logic [31:0] DataRAM_A2,
   output logic [31:0] DataRAM_WD2,
   output logic [3:0]  DataRAM_WE2,
   input  logic [31:0] DataRAM_RD2,
   output logic [31:0] InstRAM_A2,
   output logic [31:0] InstRAM_WD2,
   output logic [3:0]  InstRAM_WE2,
   input  logic [31:0] InstRAM_RD2,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state
);

   localparam logic [31:0]      LAST_ADDR = 32'(WORD_BYTES * (BRAM_WORDS - 1));
   localparam logic [31:0]      WORD_INC  = 32'(WORD_BYTES);
   localparam logic [CNT_W-1:0] RUN_END   = CNT_W'(RUN_CYCLES);

   seq_state_t       r_state;
   seq_state_t       w_state_next;
   logic [31:0]      r_addr;
   logic             r_gap;
   logic [CNT_W-1:0] r_cnt;
   logic             r_core_rst;
   logic [31:0]      r_data_a2;
   logic [31:0]      r_data_wd2;
   logic [3:0]       r_data_we2;
   logic [31:0]      r_inst_a2;
   logic [31:0]      r_inst_wd2;
   logic [3:0]       r_inst_we2;

   logic             w_loading;
   logic             w_dumping;
   logic             w_dp_inst;
   logic             w_accept;
   logic             w_ld_end;
   logic             w_issue;
   logic             w_handshake;
   logic             w_dp_end;
   logic [31:0]      w_rd_mux;

   // Handshakes: a word moves on the rising edge where valid and ready are both
   // high; a producer holds valid and data stable until then, ready may toggle.
   assign w_loading = (r_state == ST_LD_DATA) || (r_state == ST_LD_INST);
   assign w_dumping = (r_state == ST_DP_DATA) || (r_state == ST_DP_INST);
   assign w_dp_inst = (r_state == ST_DP_INST);
   assign in_ready  = w_loading && !r_gap;
   assign w_accept  = in_valid && in_ready;
   assign w_ld_end  = w_accept && (in_last || (r_addr == LAST_ADDR));
   assign w_dp_end  = w_handshake && (r_addr == LAST_ADDR);
   assign w_rd_mux  = w_dp_inst ? InstRAM_RD2 : DataRAM_RD2;

   dbg_dump_reader u_reader (
      .i_clk       (CPU_CLK),
      .i_rst       (CPU_RST),
      .i_active    (w_dumping),
      .i_addr      (r_addr),
      .i_sel       (w_dp_inst),
      .i_rd_data   (w_rd_mux),
      .i_out_ready (out_ready),
      .o_issue     (w_issue),
      .o_handshake (w_handshake),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_out_addr  (out_addr),
      .o_out_sel   (out_sel)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start) w_state_next = ST_LD_DATA;
         ST_LD_DATA:       if (w_ld_end) w_state_next = ST_LD_INST;
         ST_LD_INST:       if (w_ld_end) w_state_next = ST_RUN;
         ST_RUN:           if (r_cnt == RUN_END) w_state_next = ST_DP_DATA;
         ST_DP_DATA:       if (w_dp_end) w_state_next = ST_DP_INST;
         ST_DP_INST:       if (w_dp_end) w_state_next = ST_DONE;
         default:          w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_gap      <= 1'b0;
         r_cnt      <= '0;
         r_core_rst <= 1'b1;
         r_data_a2  <= '0;
         r_data_wd2 <= '0;
         r_data_we2 <= '0;
         r_inst_a2  <= '0;
         r_inst_wd2 <= '0;
         r_inst_we2 <= '0;
      end else begin
         r_state    <= w_state_next;
         r_data_we2 <= '0;
         r_inst_we2 <= '0;
         r_gap      <= 1'b0;
         r_core_rst <= 1'b1;
         r_cnt      <= '0;
         case (r_state)
            ST_IDLE, ST_DONE: if (start) r_addr <= '0;
            ST_LD_DATA, ST_LD_INST: begin
               if (w_accept) begin
                  if (r_state == ST_LD_DATA) begin
                     r_data_a2  <= r_addr;
                     r_data_wd2 <= in_data;
                     r_data_we2 <= WE_ALL;
                  end else begin
                     r_inst_a2  <= r_addr;
                     r_inst_wd2 <= in_data;
                     r_inst_we2 <= WE_ALL;
                  end
                  if (w_ld_end) begin
                     r_addr <= '0;
                     r_gap  <= 1'b1;
                  end else begin
                     r_addr <= r_addr + WORD_INC;
                  end
               end
            end
            ST_RUN: begin
               // First RUN cycle keeps the core in reset; release for RUN_CYCLES
               if (r_cnt != RUN_END) begin
                  r_cnt      <= r_cnt + CNT_W'(1);
                  r_core_rst <= 1'b0;
               end
            end
            ST_DP_DATA, ST_DP_INST: begin
               if (w_issue) begin
                  if (w_dp_inst) r_inst_a2 <= r_addr;
                  else           r_data_a2 <= r_addr;
               end
               if (w_dp_end)         r_addr <= '0;
               else if (w_handshake) r_addr <= r_addr + WORD_INC;
            end
            default: ;
         endcase
      end
   end

   // During ISSUE the address must reach the BRAM in the same cycle
   assign DataRAM_A2  = (w_issue && !w_dp_inst) ? r_addr : r_data_a2;
   assign InstRAM_A2  = (w_issue &&  w_dp_inst) ? r_addr : r_inst_a2;
   assign DataRAM_WD2 = r_data_wd2;
   assign DataRAM_WE2 = r_data_we2;
   assign InstRAM_WD2 = r_inst_wd2;
   assign InstRAM_WE2 = r_inst_we2;
   assign Core_RST    = r_core_rst;
   assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign done        = (r_state == ST_DONE);
   assign state       = r_state;

endmodule

// File: tb/tb_dbg_ram_sequencer.sv
// Bench for dbg_ram_sequencer: BRAM model, randomized load/dump traffic and a
// region-level reference model of writes, run window and dump contents.
module tb_dbg_ram_sequencer;

   localparam int BW = 8;
   localparam int RC = 16;

   logic        CPU_CLK;
   logic        CPU_RST;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [31:0] out_addr;
   logic        out_sel;
   logic        Core_RST;
   logic [31:0] DataRAM_A2;
   logic [31:0] DataRAM_WD2;
   logic [3:0]  DataRAM_WE2;
   logic [31:0] DataRAM_RD2;
   logic [31:0] InstRAM_A2;
   logic [31:0] InstRAM_WD2;
   logic [3:0]  InstRAM_WE2;
   logic [31:0] InstRAM_RD2;
   logic        busy;
   logic        done;
   logic [2:0]  state;

   dbg_ram_sequencer #(.BRAM_WORDS(BW), .RUN_CYCLES(RC), .CNT_W(32)) dut (
      .CPU_CLK     (CPU_CLK),
      .CPU_RST     (CPU_RST),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_addr    (out_addr),
      .out_sel     (out_sel),
      .Core_RST    (Core_RST),
      .DataRAM_A2  (DataRAM_A2),
      .DataRAM_WD2 (DataRAM_WD2),
      .DataRAM_WE2 (DataRAM_WE2),
      .DataRAM_RD2 (DataRAM_RD2),
      .InstRAM_A2  (InstRAM_A2),
      .InstRAM_WD2 (InstRAM_WD2),
      .InstRAM_WE2 (InstRAM_WE2),
      .InstRAM_RD2 (InstRAM_RD2),
      .busy        (busy),
      .done        (done),
      .state       (state)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_cnt  = 0;
   bit rd_mode  = 1'b0;   // 0: RD2 = A2 + 0x1000, 1: RD2 = stored word

   logic [31:0] data_mem [0:BW-1];
   logic [31:0] inst_mem [0:BW-1];
   logic [31:0] exp_data [0:BW-1];
   logic [31:0] exp_inst [0:BW-1];
   logic [64:0] exp_wr_q [$];    // {sel, addr, data}
   int          acc_q    [$];

   // ---------------- clock / reset ----------------
   initial CPU_CLK = 1'b0;
   always #5 CPU_CLK = ~CPU_CLK;
   always @(posedge CPU_CLK) cyc_cnt <= cyc_cnt + 1;

   task automatic step();
      @(posedge CPU_CLK);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- BRAM model ----------------
   always @(posedge CPU_CLK) begin
      if (DataRAM_WE2 == 4'hF) data_mem[DataRAM_A2[4:2]] <= DataRAM_WD2;
      if (InstRAM_WE2 == 4'hF) inst_mem[InstRAM_A2[4:2]] <= InstRAM_WD2;
      DataRAM_RD2 <= rd_mode ? data_mem[DataRAM_A2[4:2]] : DataRAM_A2 + 32'h1000;
      InstRAM_RD2 <= rd_mode ? inst_mem[InstRAM_A2[4:2]] : InstRAM_A2 + 32'h1000;
   end

   // ---------------- write scoreboard ----------------
   always @(negedge CPU_CLK) begin : wr_mon
      logic [64:0] e;
      logic        ws;
      int          ac;
      if (in_valid && in_ready) acc_q.push_back(cyc_cnt);
      if (DataRAM_WE2 != 4'h0 || InstRAM_WE2 != 4'h0) begin
         ws = (InstRAM_WE2 != 4'h0);
         check_val("wr_pending", 64'(exp_wr_q.size() > 0), 64'd1);
         e  = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '0;
         ac = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
         check_val("wr_addr_data", ws ? {InstRAM_A2, InstRAM_WD2} : {DataRAM_A2, DataRAM_WD2},
                   e[63:0]);
         check_val("wr_sel_we", {ws, ws ? InstRAM_WE2 : DataRAM_WE2}, {e[64], 4'hF});
         check_val("wr_latency", 64'(cyc_cnt), 64'(ac + 1));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [31:0] w, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      in_last  = l;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check_val("ld_ready", 64'(in_ready), 64'd1);
      step();
      in_last = 1'b0;
   endtask

   task automatic load_phase(input int d_len, input int i_len, input logic [31:0] d_base,
                             input logic [31:0] i_base, input bit last_full, input int ign_at);
      int          lens  [2];
      logic [31:0] bases [2];
      logic [31:0] w;
      logic        l;
      lens[0] = d_len;  lens[1] = i_len;
      bases[0] = d_base; bases[1] = i_base;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < lens[r]; k++) begin
            if (r == 1 && k == ign_at) begin
               in_valid = 1'b0;
               start    = 1'b1;
               step();
               start    = 1'b0;
               check_val("ign_start_state", 64'(state), 64'd2);
            end
            w = bases[r] + 32'(k);
            l = (k == lens[r] - 1) && (lens[r] < BW || last_full);
            exp_wr_q.push_back({1'(r), 32'(4 * k), w});
            if (r == 0) exp_data[k] = w;
            else        exp_inst[k] = w;
            send_word(w, l);
         end
         check_val(r == 0 ? "ld_data_end_state" : "ld_inst_end_state", 64'(state),
                   r == 0 ? 64'd2 : 64'd3);
         check_val("ld_gap_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
   endtask

   task automatic run_window();
      int n = 0;
      check_val("run_first_rst", 64'(Core_RST), 64'd1);
      step();
      while (Core_RST == 1'b0 && n < 100) begin
         n++;
         step();
      end
      check_val("run_low_cycles", 64'(n), 64'(RC));
      check_val("run_end_rst", 64'(Core_RST), 64'd1);
      check_val("run_end_state", 64'(state), 64'd4);
      check_val("run_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
   endtask

   task automatic dump_all(input int ready_mode);
      int          j = 0;
      int          cyc = 0;
      bit          stall = 1'b0;
      logic [64:0] held = '0;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic        e_sel;
      while (j < 2 * BW && cyc < 600) begin
         out_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
         if (stall) begin
            check_val("dp_hold_valid", 64'(out_valid), 64'd1);
            check_val("dp_hold_word", {out_sel, out_addr, out_data}, held);
         end
         check_val("dp_we_zero", {DataRAM_WE2, InstRAM_WE2}, 64'd0);
         stall = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               e_sel  = (j >= BW);
               e_addr = 32'(4 * (j % BW));
               e_data = !rd_mode ? e_addr + 32'h1000 : (e_sel ? exp_inst[j % BW] : exp_data[j % BW]);
               check_val("dp_word", {out_sel, out_addr, out_data}, {e_sel, e_addr, e_data});
               if (ready_mode == 0) check_val("dp_rate", 64'(cyc), 64'(3 * j + 2));
               j++;
            end else begin
               stall = 1'b1;
               held  = {out_sel, out_addr, out_data};
            end
         end
         step();
         cyc++;
      end
      out_ready = 1'b0;
      check_val("dp_count", 64'(j), 64'(2 * BW));
      check_val("done_state", {state, done, busy, Core_RST}, {3'd6, 1'b1, 1'b0, 1'b1});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("start_state", {state, busy, in_ready, Core_RST}, {3'd1, 1'b1, 1'b1, 1'b1});
   endtask

   task automatic full_cycle(input int d_len, input int i_len, input logic [31:0] d_base,
                             input logic [31:0] i_base, input bit last_full, input int ign_at,
                             input bit rmode, input int ready_mode);
      rd_mode = rmode;
      pulse_start();
      load_phase(d_len, i_len, d_base, i_base, last_full, ign_at);
      run_window();
      dump_all(ready_mode);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      CPU_RST   = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) step();
      check_val("rst_state", {state, busy, done, Core_RST}, {3'd0, 1'b0, 1'b0, 1'b1});
      check_val("rst_hs", {in_ready, out_valid, out_sel}, 64'd0);
      check_val("rst_we", {DataRAM_WE2, InstRAM_WE2}, 64'd0);
      check_val("rst_a2", {DataRAM_A2, InstRAM_A2}, 64'd0);
      check_val("rst_out", {out_data, out_addr}, 64'd0);
      CPU_RST = 1'b0;
      step();
      check_val("idle_no_start", 64'(state), 64'd0);

      // full regions ended by word count, dump with alternating backpressure
      full_cycle(BW, BW, 32'h100, 32'h200, 1'b0, -1, 1'b0, 1);
      // early end on the third data word, unstalled dump of stored contents
      full_cycle(3, BW, 32'hA8, 32'h2A0, 1'b1, -1, 1'b1, 0);
      // start pulse inside LD_INST is ignored
      full_cycle(BW, 6, 32'h5000, 32'h6000, 1'b0, 3, 1'b1, 2);

      // reset in the middle of the run window
      pulse_start();
      load_phase(5, 2, 32'h300, 32'h400, 1'b0, -1);
      repeat (5) step();
      check_val("mid_run_core_low", 64'(Core_RST), 64'd0);
      CPU_RST = 1'b1;
      step();
      check_val("mid_run_rst", {state, Core_RST, busy, DataRAM_WE2, InstRAM_WE2},
                {3'd0, 1'b1, 1'b0, 4'h0, 4'h0});
      CPU_RST = 1'b0;
      check_val("mid_run_wr_q", 64'(exp_wr_q.size()), 64'd0);
      full_cycle(BW, BW, 32'h700, 32'h800, 1'b1, -1, 1'b1, 2);

      for (int t = 0; t < 4; t++) begin
         full_cycle(int'($urandom_range(1, BW)), int'($urandom_range(1, BW)), $urandom,
                    $urandom, 1'($urandom_range(0, 1)), -1, 1'b1, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
